urv_div_ctrl: RTL
=================

Name: urv_div_ctrl

Overview:
Sequencing front-end for the iterative unsigned divide core in the execute stage. Accepts DIV/DIVU/REM/REMU requests from the decode/execute handshake and owns the start/done handshake to the core, including operand sign conversion and result sign fix-up. Divide-by-zero and signed overflow are resolved without a core run. A one-entry result cache returns both quotient and remainder, so a REM following a DIV on identical operands completes in one cycle.

Parameters:
G_CACHE_EN, 1, enables the last-result cache (0: every non-special request runs the core)
G_SPECIAL_EN, 1, enables the div-by-zero/overflow fast path (0: these cases run the core; core output is fixed up normally)

Ports:
clk_i  in  1  core clock
rst_n_i  in  1  asynchronous active-low reset
x_stall_i  in  1  pipeline stall from downstream
x_kill_i  in  1  kill of the instruction in decode/execute
x_stall_req_o  out  1  stall request while a divide is unresolved
d_valid_i  in  1  decode slot valid
d_is_divide_i  in  1  decode instruction is DIV/DIVU/REM/REMU
d_fun_i  in  3  funct3 (bit0=unsigned, bit1=remainder)
d_rs1_i  in  32  dividend
d_rs2_i  in  32  divisor
x_rd_o  out  32  result, valid in RESP
div_start_o  out  1  one-cycle start pulse to core
div_n_o  out  32  unsigned dividend magnitude, held from start to done
div_d_o  out  32  unsigned divisor magnitude, held from start to done
div_done_i  in  1  one-cycle core completion pulse
div_q_i  in  32  unsigned quotient, valid with div_done_i
div_r_i  in  32  unsigned remainder, valid with div_done_i

Behaviour:
- Reset (async, rst_n_i=0): state=IDLE, x_rd_o=0, div_start_o=0, div_n_o=0, div_d_o=0, cache valid=0, x_stall_req_o=0.
- req = d_valid_i & d_is_divide_i & !x_kill_i. x_stall_req_o = d_valid_i & d_is_divide_i & (state != RESP).
- Signed op: sn=rs1[31] & !fun[0], sd=rs2[31] & !fun[0]. Magnitudes are two's-complement negated when the sign flag is set.
- IDLE, req:
  - Special (G_SPECIAL_EN): rs2==0 gives q=0xFFFFFFFF, r=rs1. Signed rs1=0x80000000 with rs2=0xFFFFFFFF gives q=0x80000000, r=0. Select by fun[1], go to RESP. No core start; cache unchanged.
  - Cache hit: valid & key match (rs1, rs2, fun[0]). Select cached q/r by fun[1], go to RESP.
  - Otherwise: latch operands, signs, fun; drive magnitudes; pulse div_start_o; go to WAIT.
- WAIT, on div_done_i: q_s = (sn^sd) ? -q : q; r_s = sn ? -r : r. Write the cache (key, q_s, r_s, valid=1). x_rd_o = fun[1] ? r_s : q_s. Go to RESP.
- WAIT, x_kill_i=1 without div_done_i: go to ABORT. If kill and done coincide, kill wins: result discarded, cache not written, go to IDLE.
- ABORT: x_stall_req_o follows the formula. On div_done_i, discard and go to IDLE; cache not written. A new request waits in IDLE until the core is free.
- RESP: x_rd_o is stable and x_stall_req_o=0. Stay while x_stall_i=1; go to IDLE when x_stall_i=0. x_kill_i is ignored.
- Latency:
  - Special or hit: request seen in IDLE at cycle T; RESP at T+1.
  - Miss: start at T; core done at T+k; RESP at T+k+1.
- div_start_o is never asserted outside IDLE. Only one core operation is outstanding.
- All arithmetic is 32-bit modulo 2^32.

Decomposition:
- Shared package (urv_defs): FUNC_DIV=3'b100, FUNC_DIVU=3'b101, FUNC_REM=3'b110, FUNC_REMU=3'b111; state encodings IDLE/WAIT/ABORT/RESP.
- Optional sub-module urv_div_cache: key compare plus q/r storage, with write, invalidate-on-reset and hit outputs.

Test Plan:
- DIVU 20,3 with a k=33 core model: one start pulse, div_n_o=20, div_d_o=3; x_rd_o=6 in RESP at T+34. Then REMU 20,3: x_rd_o=2 at T+1 with no start pulse.
- DIVU 5,0 gives 0xFFFFFFFF and REMU 5,0 gives 5, each in 1 cycle with no start. DIV 0x80000000,0xFFFFFFFF gives 0x80000000; REM of the same operands gives 0.
- DIV 0xFFFFFFF9(-7),2: div_n_o=7, div_d_o=2, x_rd_o=0xFFFFFFFD. REM of the same operands hits the cache and returns 0xFFFFFFFF.
- Cache key separation: DIV -7,2 then DIVU 0xFFFFFFF9,2 misses and starts the core; x_rd_o=0x7FFFFFFC.
- Kill at WAIT+5: enters ABORT; done is discarded; cache is not written. A new DIVU 9,3 stalls until done, then starts: x_rd_o=3.
- rst_n_i low mid-WAIT: state=IDLE immediately and cache invalid. A repeat of the prior operands misses and issues a start.

Source files
------------

// File: rtl/urv_defs.sv
// Shared definitions for the divide sequencer: funct3 encodings, FSM states, result-cache key.
// Pure declarations; no latency or flow-control behaviour of its own.
package urv_defs;

  localparam logic [2:0] FUNC_DIV  = 3'b100;
  localparam logic [2:0] FUNC_DIVU = 3'b101;
  localparam logic [2:0] FUNC_REM  = 3'b110;
  localparam logic [2:0] FUNC_REMU = 3'b111;

  localparam int FUN_UNS = 0;
  localparam int FUN_REM = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2,
    ST_RESP  = 2'd3
  } div_state_t;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        uns;
  } div_key_t;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/urv_div_ctrl_if.sv
// Start/done handshake between the divide sequencer (master) and the iterative core (slave).
// Operands are held by the master from start until done; the core answers with a one-cycle done pulse.
interface urv_div_ctrl_if;

  logic        div_start_o;
  logic [31:0] div_n_o;
  logic [31:0] div_d_o;
  logic        div_done_i;
  logic [31:0] div_q_i;
  logic [31:0] div_r_i;

  modport master (
    output div_start_o, div_n_o, div_d_o,
    input  div_done_i, div_q_i, div_r_i
  );

  modport slave (
    input  div_start_o, div_n_o, div_d_o,
    output div_done_i, div_q_i, div_r_i
  );

endinterface

// File: rtl/urv_div_cache.sv
// One-entry cache of the last signed-corrected quotient/remainder pair, keyed on operands and signedness.
// Hit is combinational on the lookup key; a write lands on the next edge; never stalls.
module urv_div_cache
  import urv_defs::*;
#(
  parameter bit G_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  div_key_t    wr_key,
  input  logic [31:0] wr_q,
  input  logic [31:0] wr_r,
  input  div_key_t    key,
  output logic        hit,
  output logic [31:0] q,
  output logic [31:0] r
);

  logic     vld;
  div_key_t key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= 1'b0;
      key_q <= '0;
      q     <= '0;
      r     <= '0;
    end else if (wr && G_EN) begin
      vld   <= 1'b1;
      key_q <= wr_key;
      q     <= wr_q;
      r     <= wr_r;
    end
  end

  assign hit = G_EN && vld && (key_q == key);

endmodule

// File: rtl/urv_div_ctrl.sv
// Divide sequencer: sign handling, special-case fast path and result cache around an unsigned core.
// Special/hit resolve in 1 cycle, core runs in k+1; requests stall the pipe until RESP, RESP holds under x_stall_i.
module urv_div_ctrl
  import urv_defs::*;
#(
  parameter bit G_CACHE_EN   = 1'b1,
  parameter bit G_SPECIAL_EN = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          x_stall_i,
  input  logic          x_kill_i,
  output logic          x_stall_req_o,
  input  logic          d_valid_i,
  input  logic          d_is_divide_i,
  input  logic [2:0]    d_fun_i,
  input  logic [31:0]   d_rs1_i,
  input  logic [31:0]   d_rs2_i,
  output logic [31:0]   x_rd_o,
  urv_div_ctrl_if.master core
);

  div_state_t  state;
  logic        req;
  logic        sgn_n;
  logic        sgn_d;
  logic        is_zero;
  logic        is_ovf;
  logic        special;
  logic [31:0] sp_q;
  logic [31:0] sp_r;
  div_key_t    lk_key;
  div_key_t    op_key;
  logic        op_sn;
  logic        op_sd;
  logic        op_rem;
  logic        c_hit;
  logic [31:0] c_q;
  logic [31:0] c_r;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic        c_wr;
  logic        unused_fun2;

  assign req           = d_valid_i & d_is_divide_i & ~x_kill_i;
  assign x_stall_req_o = d_valid_i & d_is_divide_i & (state != ST_RESP);

  assign sgn_n = d_rs1_i[31] & ~d_fun_i[FUN_UNS];
  assign sgn_d = d_rs2_i[31] & ~d_fun_i[FUN_UNS];

  // Only the signed form can overflow; a zero divisor is special for both forms.
  assign is_zero = (d_rs2_i == 32'd0);
  assign is_ovf  = ~d_fun_i[FUN_UNS] & (d_rs1_i == 32'h8000_0000) & (d_rs2_i == 32'hFFFF_FFFF);
  assign special = G_SPECIAL_EN & (is_zero | is_ovf);
  assign sp_q    = is_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
  assign sp_r    = is_zero ? d_rs1_i : 32'd0;

  assign lk_key      = {d_rs1_i, d_rs2_i, d_fun_i[FUN_UNS]};
  assign unused_fun2 = d_fun_i[2];

  // Quotient sign follows the sign mismatch, remainder sign follows the dividend.
  assign q_s  = neg_if(op_sn ^ op_sd, core.div_q_i);
  assign r_s  = neg_if(op_sn, core.div_r_i);
  assign c_wr = (state == ST_WAIT) & core.div_done_i & ~x_kill_i;

  urv_div_cache #(
    .G_EN (G_CACHE_EN)
  ) u_cache (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .wr     (c_wr),
    .wr_key (op_key),
    .wr_q   (q_s),
    .wr_r   (r_s),
    .key    (lk_key),
    .hit    (c_hit),
    .q      (c_q),
    .r      (c_r)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state            <= ST_IDLE;
      x_rd_o           <= '0;
      core.div_start_o <= 1'b0;
      core.div_n_o     <= '0;
      core.div_d_o     <= '0;
      op_key           <= '0;
      op_sn            <= 1'b0;
      op_sd            <= 1'b0;
      op_rem           <= 1'b0;
    end else begin
      core.div_start_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            if (special) begin
              x_rd_o <= d_fun_i[FUN_REM] ? sp_r : sp_q;
              state  <= ST_RESP;
            end else if (c_hit) begin
              x_rd_o <= d_fun_i[FUN_REM] ? c_r : c_q;
              state  <= ST_RESP;
            end else begin
              op_key           <= lk_key;
              op_sn            <= sgn_n;
              op_sd            <= sgn_d;
              op_rem           <= d_fun_i[FUN_REM];
              core.div_n_o     <= neg_if(sgn_n, d_rs1_i);
              core.div_d_o     <= neg_if(sgn_d, d_rs2_i);
              core.div_start_o <= 1'b1;
              state            <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // A kill coinciding with done drops the result; the core is already free.
          if (x_kill_i) begin
            state <= core.div_done_i ? ST_IDLE : ST_ABORT;
          end else if (core.div_done_i) begin
            x_rd_o <= op_rem ? r_s : q_s;
            state  <= ST_RESP;
          end
        end
        ST_ABORT: begin
          if (core.div_done_i) begin
            state <= ST_IDLE;
          end
        end
        ST_RESP: begin
          if (!x_stall_i) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
